axi_sram_read_slave: RTL and testbench

Slave-side AXI4 read engine that accepts AR requests from the address crossbar, reads a single-port synchronous SRAM, and emits R beats (RID/RDATA/RRESP/RLAST/RVALID) toward the read-data crossbar. It sits directly upstream of the R-channel mux, one instance per SRAM slave port. RID carries the full interconnect ID (master index in the upper bits), so the mux can route beats back to the issuing master.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_burst_addr.sv | 74 +++++++
 rtl/axi_sram_read_slave.sv | 138 +++++++++++++
 tb/tb_axi_sram_read_slave.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI read-path types and constants: burst encoding,
//               response codes, default widths and the read-slave FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // Default widths used by the interconnect
    localparam int AXI_IDS_BITS  = 8;   // master index + master ID
    localparam int AXI_ID_BITS   = 4;   // master-local ID
    localparam int AXI_DATA_BITS = 32;

    // ARBURST encoding; 2'b11 is reserved and treated like WRAP (error)
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    // RRESP encoding
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Read-slave FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr
// Description : Word-address and beat-counter tracker for one read burst.
//               Loaded at the AR handshake, stepped after each non-final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [LEN_W-1:0]  i_load_len,
    input  logic [1:0]        i_load_burst,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] w_addr_d;
    logic [LEN_W-1:0]  r_cnt_q;
    logic [LEN_W-1:0]  w_cnt_d;
    logic [1:0]        r_burst_q;
    logic [1:0]        w_burst_d;
    logic [ADDR_W-1:0] w_next_addr;

    // Next word address: INCR wraps naturally modulo 2^ADDR_W; FIXED and the
    // error bursts keep the address (the SRAM is not accessed for errors).
    always_comb begin
        w_next_addr = r_addr_q;
        if (r_burst_q == BURST_INCR) begin
            w_next_addr = r_addr_q + ADDR_W'(1);
        end
    end

    // Load on handshake, otherwise advance on step
    always_comb begin
        w_addr_d  = r_addr_q;
        w_cnt_d   = r_cnt_q;
        w_burst_d = r_burst_q;
        if (i_load) begin
            w_addr_d  = i_load_addr;
            w_cnt_d   = i_load_len;
            w_burst_d = i_load_burst;
        end else if (i_step) begin
            w_addr_d = w_next_addr;
            w_cnt_d  = r_cnt_q - LEN_W'(1);
        end
    end

    // Address/counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
        end else begin
            r_addr_q  <= w_addr_d;
            r_cnt_q   <= w_cnt_d;
            r_burst_q <= w_burst_d;
        end
    end

    assign o_addr = r_addr_q;
    assign o_last = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/axi_sram_read_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_read_slave
// Description : AXI4 read slave in front of a single-port synchronous SRAM.
//               One burst at a time; each beat costs one SRAM access cycle
//               plus one R-channel cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_read_slave
    import axi_pkg::*;
#(
    parameter int IDS_BITS       = AXI_IDS_BITS,
    parameter int ADDR_BITS      = 32,
    parameter int DATA_BITS      = AXI_DATA_BITS,
    parameter int LEN_BITS       = 4,
    parameter int SRAM_ADDR_BITS = 14
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [IDS_BITS-1:0]       ARID,
    input  logic [ADDR_BITS-1:0]      ARADDR,
    input  logic [LEN_BITS-1:0]       ARLEN,
    input  logic [2:0]                ARSIZE,
    input  logic [1:0]                ARBURST,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [IDS_BITS-1:0]       RID,
    output logic [DATA_BITS-1:0]      RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic                      SRAM_CS,
    output logic [SRAM_ADDR_BITS-1:0] SRAM_A,
    input  logic [DATA_BITS-1:0]      SRAM_DO
);

    rd_state_e               r_state_q;
    rd_state_e               w_state_d;
    logic [IDS_BITS-1:0]     r_id_q;
    logic [IDS_BITS-1:0]     w_id_d;
    logic                    r_err_q;
    logic                    w_err_d;
    logic                    r_arready_q;
    logic                    w_arready_d;
    logic                    w_load;
    logic                    w_step;
    logic                    w_last;
    logic [SRAM_ADDR_BITS-1:0] w_addr;
    logic                    w_unused;

    // Size is fixed at 4 bytes and the byte offset / high address bits are
    // meaningless for this word-addressed SRAM.
    assign w_unused = ^{ARSIZE, ARADDR[1:0], ARADDR[ADDR_BITS-1:SRAM_ADDR_BITS+2]};

    axi_burst_addr #(
        .ADDR_W (SRAM_ADDR_BITS),
        .LEN_W  (LEN_BITS)
    ) u_burst_addr (
        .clk          (ACLK),
        .rst          (ARESET),
        .i_load       (w_load),
        .i_load_addr  (ARADDR[SRAM_ADDR_BITS+1:2]),
        .i_load_len   (ARLEN),
        .i_load_burst (ARBURST),
        .i_step       (w_step),
        .o_addr       (w_addr),
        .o_last       (w_last)
    );

    // Next-state logic: IDLE accepts, ADDR strobes the SRAM, DATA presents a beat
    always_comb begin
        w_state_d = r_state_q;
        w_load    = 1'b0;
        w_step    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (ARVALID && r_arready_q) begin
                    w_load    = 1'b1;
                    w_state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                w_state_d = S_DATA;
            end
            S_DATA: begin
                if (RREADY) begin
                    if (w_last) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_step    = 1'b1;
                        w_state_d = S_ADDR;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Request attributes captured at the handshake; ARREADY is registered so
    // it stays low through reset and rises one edge after release.
    always_comb begin
        w_id_d      = w_load ? ARID : r_id_q;
        w_err_d     = w_load ? ARBURST[1] : r_err_q;
        w_arready_d = (w_state_d == S_IDLE);
    end

    // State and request registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q   <= S_IDLE;
            r_id_q      <= '0;
            r_err_q     <= 1'b0;
            r_arready_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_id_q      <= w_id_d;
            r_err_q     <= w_err_d;
            r_arready_q <= w_arready_d;
        end
    end

    // Moore outputs; RDATA relies on the SRAM holding its output while CS is low
    always_comb begin
        ARREADY = r_arready_q;
        RVALID  = (r_state_q == S_DATA);
        RLAST   = RVALID && w_last;
        RID     = r_id_q;
        RDATA   = (RVALID && !r_err_q) ? SRAM_DO : '0;
        RRESP   = (RVALID && r_err_q) ? RESP_SLVERR : RESP_OKAY;
        SRAM_CS = (r_state_q == S_ADDR) && !r_err_q;
        SRAM_A  = w_addr;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_read_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_read_slave
// Description : Directed bench for axi_sram_read_slave with a behavioural
//               synchronous SRAM and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_read_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        SRAM_CS;
    logic [13:0] SRAM_A;
    logic [31:0] sram_do = 32'h0;

    logic [31:0] mem [0:16383];
    int          cs_count = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    axi_sram_read_slave u_dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARSIZE  (ARSIZE),
        .ARBURST (ARBURST),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .SRAM_CS (SRAM_CS),
        .SRAM_A  (SRAM_A),
        .SRAM_DO (sram_do)
    );

    // Synchronous SRAM: output updates only on a strobed edge, held otherwise
    always @(posedge clk) begin
        if (SRAM_CS) begin
            sram_do  <= mem[SRAM_A];
            cs_count <= cs_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issue one AR and walk every beat; stall_beat < 0 means no stall
    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int stall_beat, input int stall_cyc);
        logic [13:0] a;
        logic        err;
        logic [31:0] exp_data;
        int          cs0;
        int          waits;
        a   = addr[15:2];
        err = burst[1];
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (ARREADY === 1'b1) break;
            waits++;
            if (waits > 20) begin
                check("arready_timeout", 32'(ARREADY), 32'h1);
                ARVALID = 1'b0;
                return;
            end
        end
        cs0 = cs_count;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            check($sformatf("id%h_b%0d_cs", id, i), 32'(SRAM_CS), 32'(!err));
            check($sformatf("id%h_b%0d_sram_a", id, i), 32'(SRAM_A), 32'(a));
            check($sformatf("id%h_b%0d_rvalid_addr", id, i), 32'(RVALID), 32'h0);
            check($sformatf("id%h_b%0d_arready_busy", id, i), 32'(ARREADY), 32'h0);
            @(posedge clk); #1;
            exp_data = err ? 32'h0 : mem[a];
            check($sformatf("id%h_b%0d_rvalid", id, i), 32'(RVALID), 32'h1);
            check($sformatf("id%h_b%0d_rid", id, i), 32'(RID), 32'(id));
            check($sformatf("id%h_b%0d_rdata", id, i), RDATA, exp_data);
            check($sformatf("id%h_b%0d_rresp", id, i), 32'(RRESP), err ? 32'h2 : 32'h0);
            check($sformatf("id%h_b%0d_rlast", id, i), 32'(RLAST), 32'(i == int'(len)));
            if (i == stall_beat) begin
                RREADY = 1'b0;
                repeat (stall_cyc) begin
                    @(posedge clk); #1;
                    check($sformatf("id%h_stall_rvalid", id), 32'(RVALID), 32'h1);
                    check($sformatf("id%h_stall_rdata", id), RDATA, exp_data);
                    check($sformatf("id%h_stall_rid", id), 32'(RID), 32'(id));
                    check($sformatf("id%h_stall_rlast", id), 32'(RLAST), 32'(i == int'(len)));
                    check($sformatf("id%h_stall_cs", id), 32'(SRAM_CS), 32'h0);
                end
                RREADY = 1'b1;
            end
            @(posedge clk); #1;
            if (burst == 2'b01) a = a + 14'd1;
        end
        check($sformatf("id%h_idle_arready", id), 32'(ARREADY), 32'h1);
        check($sformatf("id%h_idle_rvalid", id), 32'(RVALID), 32'h0);
        check($sformatf("id%h_cs_pulses", id), 32'(cs_count - cs0), err ? 32'h0 : 32'(int'(len) + 1));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h5A5A_0000 ^ 32'(i);
        mem[4]     = 32'hDEAD_BEEF;
        mem[0]     = 32'h0000_0100;
        mem[1]     = 32'h0000_0101;
        mem[2]     = 32'h0000_0102;
        mem[3]     = 32'h0000_0103;
        mem[8]     = 32'hCAFE_0008;
        mem[16383] = 32'hAAAA_5555;

        rst = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010;
        ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", 32'(ARREADY), 32'h0);
        check("rst_rvalid", 32'(RVALID), 32'h0);
        check("rst_rlast", 32'(RLAST), 32'h0);
        check("rst_cs", 32'(SRAM_CS), 32'h0);
        check("rst_sram_a", 32'(SRAM_A), 32'h0);
        check("rst_rid", 32'(RID), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_arready_low", 32'(ARREADY), 32'h0);
        @(posedge clk); #1;
        check("release_arready_high", 32'(ARREADY), 32'h1);

        run_burst(8'h12, 32'h0000_0010, 4'd0, 2'b01, -1, 0);   // single read
        run_burst(8'h34, 32'h0000_0000, 4'd3, 2'b01, -1, 0);   // INCR x4
        run_burst(8'h35, 32'h0000_0000, 4'd3, 2'b01, 1, 5);    // backpressure on beat 2
        run_burst(8'h56, 32'h0000_0020, 4'd2, 2'b00, -1, 0);   // FIXED x3
        run_burst(8'h78, 32'h0000_0040, 4'd1, 2'b10, -1, 0);   // WRAP -> SLVERR
        run_burst(8'h79, 32'h0000_0044, 4'd0, 2'b11, -1, 0);   // reserved -> SLVERR
        run_burst(8'h9A, 32'h0000_FFFC, 4'd1, 2'b01, -1, 0);   // word 0x3FFF wraps to 0

        // Reset in the middle of a 4-beat burst
        ARID = 8'h55; ARADDR = 32'h0; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge clk);
        check("mid_arready", 32'(ARREADY), 32'h1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        RREADY  = 1'b0;
        @(posedge clk); #1;
        check("mid_rvalid_before", 32'(RVALID), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("mid_rvalid_async", 32'(RVALID), 32'h0);
        check("mid_arready_rst", 32'(ARREADY), 32'h0);
        check("mid_rid_rst", 32'(RID), 32'h0);
        check("mid_sram_a_rst", 32'(SRAM_A), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        RREADY = 1'b1;
        @(posedge clk); #1;
        check("mid_arready_after", 32'(ARREADY), 32'h1);
        run_burst(8'h12, 32'h0000_0010, 4'd0, 2'b01, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
